// File: rtl/ct_addr_seq.sv
// rtl/ct_addr_seq.sv - control-and-timing address sequencer for the bit-serial ROM
//
// Owns the 56-bit-time word counter, frames the ROM with sync, shifts the
// program address out on ia, captures the returned instruction from is and
// computes the next program address (increment, jsb, conditional goto, return).
//
// Optional feature macro: CT_RET_STACK2_EN
//   undefined : single return register
//   defined   : two-entry return stack (d_ret shows the top entry)
//
// Ports:
//   cph2     in   system clock, all state on rising edge
//   pon      in   asynchronous active-low power-on reset
//   is       in   serial instruction from ROM, LSB first
//   carry    in   carry flag from arithmetic chip, any bit time
//   sync     out  word-frame marker, high for t=46..55
//   ia       out  serial ROM address, LSB first, t=T_IA0..T_IA0+7
//   inst     out  last captured instruction word
//   inst_vld out  one-cycle pulse during t=55
//   d_pc     out  debug: current program counter
//   d_ret    out  debug: return-stack top

module ct_addr_seq #(
  parameter logic [7:0] RST_PC = 8'h00,
  parameter int         T_IA0  = 19,
  parameter int         T_IS0  = 45
) (
  input  logic       cph2,
  input  logic       pon,
  input  logic       is,
  input  logic       carry,
  output logic       sync,
  output logic       ia,
  output logic [9:0] inst,
  output logic       inst_vld,
  output logic [7:0] d_pc,
  output logic [7:0] d_ret
);

  localparam logic [5:0] T_LAST   = 6'd55;
  localparam logic [5:0] T_SYNC0  = 6'd46;
  localparam logic [5:0] IA_LO    = 6'(T_IA0);
  localparam logic [5:0] IA_HI    = 6'(T_IA0 + 7);
  localparam logic [5:0] IS_LO    = 6'(T_IS0);
  localparam logic [5:0] IS_HI    = 6'(T_IS0 + 9);
  localparam logic [9:0] W_RETURN = 10'b00_0011_0000;

  logic [5:0] t;
  logic [5:0] t_nxt;
  logic [5:0] ia_idx;
  logic [7:0] pc;
  logic [7:0] pc_nxt;
  logic [7:0] pc_inc;
  logic [7:0] ret;
  logic [7:0] ret_nxt;
  logic [9:0] ish;
  logic       carry_l;
  logic       carry_eff;
  logic       word_end;
`ifdef CT_RET_STACK2_EN
  logic [7:0] ret1;
  logic [7:0] ret1_nxt;
`endif

  assign word_end  = (t == T_LAST);
  assign t_nxt     = word_end ? 6'd0 : t + 6'd1;
  assign pc_inc    = pc + 8'd1;
  // The t=55 carry still counts toward the word it belongs to.
  assign carry_eff = carry_l | carry;

  // ia is combinational so it is valid for the whole bit time; the ROM
  // samples mid-cycle and pc only moves at t=55, well outside the window.
  assign ia_idx = t - IA_LO;
  assign ia     = ((t >= IA_LO) && (t <= IA_HI)) ? pc[ia_idx[2:0]] : 1'b0;

  assign d_pc  = pc;
  assign d_ret = ret;

  always_comb begin
    pc_nxt  = pc_inc;
    ret_nxt = ret;
`ifdef CT_RET_STACK2_EN
    ret1_nxt = ret1;
`endif
    if (ish[1:0] == 2'b01) begin
      // jsb: push pc+1 (wraps modulo 256) and jump
      ret_nxt = pc_inc;
      pc_nxt  = ish[9:2];
`ifdef CT_RET_STACK2_EN
      ret1_nxt = ret;
`endif
    end else if (ish[1:0] == 2'b11) begin
      // conditional goto is taken only when no carry occurred this word
      pc_nxt = carry_eff ? pc_inc : ish[9:2];
    end else if (ish == W_RETURN) begin
      pc_nxt = ret;
`ifdef CT_RET_STACK2_EN
      ret_nxt = ret1;
`endif
    end
  end

  always_ff @(posedge cph2 or negedge pon) begin
    if (!pon) begin
      t        <= 6'd0;
      pc       <= RST_PC;
      ret      <= 8'h00;
      inst     <= 10'h000;
      ish      <= 10'h000;
      carry_l  <= 1'b0;
      sync     <= 1'b0;
      inst_vld <= 1'b0;
`ifdef CT_RET_STACK2_EN
      ret1     <= 8'h00;
`endif
    end else begin
      t        <= t_nxt;
      // Registered from t_nxt so sync lines up exactly with t=46..55.
      sync     <= (t_nxt >= T_SYNC0);
      inst_vld <= (t_nxt == T_LAST);

      // Bits arrive LSB first, so a right shift leaves bit 0 at ish[0]
      // after the tenth sample.
      if ((t >= IS_LO) && (t <= IS_HI)) begin
        ish <= {is, ish[9:1]};
      end

      if (word_end) begin
        inst    <= ish;
        pc      <= pc_nxt;
        ret     <= ret_nxt;
        carry_l <= 1'b0;
`ifdef CT_RET_STACK2_EN
        ret1    <= ret1_nxt;
`endif
      end else begin
        carry_l <= carry_eff;
      end
    end
  end

endmodule
